// File: rtl/queue_mc_pkg.sv
// queue_mc_pkg: shared declarations for the multi-channel queue.
//   cnt_width()  - bits needed to hold an occupancy of 0..depth
//   ch_status_t  - per-channel flag bundle returned by queue_mc_ch
package queue_mc_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } ch_status_t;

endpackage

// File: rtl/queue_mc_ch.sv
// queue_mc_ch: one first-word-fall-through FIFO channel.
// Optional feature: define QUEUE_MC_PEAK_EN to build the high-water-mark register.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   push_flag, push_data  write request and word
//   pop_flag              read request (head word is already on pop_data)
//   err_clr               clears sticky overflow/underflow (and reloads peak)
//   pop_data              head word, 0 while empty
//   status                full/empty/watermarks/sticky errors
//   size, peak            occupancy and high-water mark (peak=0 without the macro)
module queue_mc_ch
  import queue_mc_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 8,
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 1,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int CNT_W     = cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push_flag,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop_flag,
  input  logic                 err_clr,
  output logic [DATA_SIZE-1:0] pop_data,
  output ch_status_t           status,
  output logic [CNT_W-1:0]     size,
  output logic [CNT_W-1:0]     peak
);

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf;
  logic                 r_unf;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push_ok;
  logic                 w_pop_ok;
  logic [CNT_W-1:0]     w_cnt_nxt;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full    = (r_cnt == CNT_W'(DEPTH));
  assign w_empty   = (r_cnt == '0);
  // A push into a full channel is accepted when a pop frees the slot in the same cycle.
  assign w_push_ok = push_flag & (~w_full | pop_flag);
  assign w_pop_ok  = pop_flag & ~w_empty;
  assign w_cnt_nxt = r_cnt + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      if (w_push_ok) r_head <= next_ptr(r_head);
      if (w_pop_ok)  r_tail <= next_ptr(r_tail);
      r_cnt <= w_cnt_nxt;
      // A new error in the same cycle as err_clr keeps the flag set.
      r_ovf <= (push_flag & ~w_push_ok) | (r_ovf & ~err_clr);
      r_unf <= (pop_flag & ~w_pop_ok)   | (r_unf & ~err_clr);
    end
  end

  // NOTE: the storage array has no reset; stale entries are unreachable because
  // pop_data is masked while empty, and a reset only has to clear the pointers.
  // The write is still blocked while reset_n is low so nothing lands on a reset edge.
  always_ff @(posedge clk) begin
    if (w_push_ok && reset_n) r_mem[r_head] <= push_data;
  end

  assign pop_data = w_empty ? '0 : r_mem[r_tail];

  assign status.full         = w_full;
  assign status.empty        = w_empty;
  assign status.almost_full  = (r_cnt >= CNT_W'(AF_LEVEL));
  assign status.almost_empty = (r_cnt <= CNT_W'(AE_LEVEL));
  assign status.overflow     = r_ovf;
  assign status.underflow    = r_unf;
  assign size                = r_cnt;

`ifdef QUEUE_MC_PEAK_EN
  logic [CNT_W-1:0] r_peak;

  // Tracks the post-edge count so peak and size move on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_peak <= '0;
    end else if (err_clr) begin
      r_peak <= w_cnt_nxt;
    end else if (w_cnt_nxt > r_peak) begin
      r_peak <= w_cnt_nxt;
    end
  end

  assign peak = r_peak;
`else
  assign peak = '0;
`endif

endmodule

// File: rtl/queue_mc.sv
// queue_mc: NUM_CH independent first-word-fall-through FIFOs on one clock/reset.
// Optional feature: define QUEUE_MC_PEAK_EN to enable per-channel peak tracking;
// otherwise the peak bus reads 0.
// Ports (channel c occupies slice c of every bus):
//   clk, reset_n                     clock, asynchronous active-low reset
//   push_flag, push_data             per-channel write request / word
//   pop_flag, pop_data               per-channel read request / head word
//   err_clr                          per-channel clear of sticky errors (and peak)
//   full, empty, almost_full,
//   almost_empty                     per-channel occupancy flags
//   size, peak                       per-channel occupancy / high-water mark
//   overflow, underflow              per-channel sticky error flags
module queue_mc
  import queue_mc_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 8,
  parameter int NUM_CH    = 4,
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 1,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int CNT_W     = cnt_width(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_CH-1:0]           push_flag,
  input  logic [NUM_CH*DATA_SIZE-1:0] push_data,
  input  logic [NUM_CH-1:0]           pop_flag,
  output logic [NUM_CH*DATA_SIZE-1:0] pop_data,
  input  logic [NUM_CH-1:0]           err_clr,
  output logic [NUM_CH-1:0]           full,
  output logic [NUM_CH-1:0]           empty,
  output logic [NUM_CH-1:0]           almost_full,
  output logic [NUM_CH-1:0]           almost_empty,
  output logic [NUM_CH*CNT_W-1:0]     size,
  output logic [NUM_CH-1:0]           overflow,
  output logic [NUM_CH-1:0]           underflow,
  output logic [NUM_CH*CNT_W-1:0]     peak
);

  if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH && DEPTH >= 2)) begin : g_bad_cfg
    $fatal(1, "queue_mc: need DEPTH>=2 and AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  ch_status_t w_status [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    queue_mc_ch #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (DEPTH),
      .AF_LEVEL  (AF_LEVEL),
      .AE_LEVEL  (AE_LEVEL),
      .PTR_W     (PTR_W),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .push_flag (push_flag[c]),
      .push_data (push_data[c*DATA_SIZE +: DATA_SIZE]),
      .pop_flag  (pop_flag[c]),
      .err_clr   (err_clr[c]),
      .pop_data  (pop_data[c*DATA_SIZE +: DATA_SIZE]),
      .status    (w_status[c]),
      .size      (size[c*CNT_W +: CNT_W]),
      .peak      (peak[c*CNT_W +: CNT_W])
    );

    assign full[c]         = w_status[c].full;
    assign empty[c]        = w_status[c].empty;
    assign almost_full[c]  = w_status[c].almost_full;
    assign almost_empty[c] = w_status[c].almost_empty;
    assign overflow[c]     = w_status[c].overflow;
    assign underflow[c]    = w_status[c].underflow;
  end

endmodule

// File: tb/tb_queue_mc.sv
// tb_queue_mc: directed self-checking bench for queue_mc.
// u_dut uses the default geometry (4 channels x 8 deep); u_dut5 is a 2-channel,
// DEPTH=5 instance used for the non-power-of-two pointer-wrap sequence.
module tb_queue_mc;

  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int CW  = 4;   // cnt_width(8)
  localparam int CW5 = 3;   // cnt_width(5)

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [NCH-1:0]      push_flag = '0;
  logic [NCH*DW-1:0]   push_data = '0;
  logic [NCH-1:0]      pop_flag  = '0;
  logic [NCH-1:0]      err_clr   = '0;
  logic [NCH*DW-1:0]   pop_data;
  logic [NCH-1:0]      full, empty, almost_full, almost_empty, overflow, underflow;
  logic [NCH*CW-1:0]   size, peak;

  logic [1:0]          p5_push  = '0;
  logic [2*DW-1:0]     p5_pdata = '0;
  logic [1:0]          p5_pop   = '0;
  logic [1:0]          p5_clr   = '0;
  logic [2*DW-1:0]     d5_data;
  logic [1:0]          d5_full, d5_empty, d5_af, d5_ae, d5_ovf, d5_unf;
  logic [2*CW5-1:0]    d5_size, d5_peak;

  int n_checks = 0;
  int n_errors = 0;

  // push / pop / both pattern for the DEPTH=5 sequence, keeps occupancy in 3..5
  int pat [6] = '{1, 1, 3, 2, 2, 3};

  always #5 clk = ~clk;

  queue_mc u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_flag    (push_flag),
    .push_data    (push_data),
    .pop_flag     (pop_flag),
    .pop_data     (pop_data),
    .err_clr      (err_clr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .size         (size),
    .overflow     (overflow),
    .underflow    (underflow),
    .peak         (peak)
  );

  queue_mc #(.DEPTH(5), .NUM_CH(2)) u_dut5 (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_flag    (p5_push),
    .push_data    (p5_pdata),
    .pop_flag     (p5_pop),
    .pop_data     (d5_data),
    .err_clr      (p5_clr),
    .full         (d5_full),
    .empty        (d5_empty),
    .almost_full  (d5_af),
    .almost_empty (d5_ae),
    .size         (d5_size),
    .overflow     (d5_ovf),
    .underflow    (d5_unf),
    .peak         (d5_peak)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] sz(input int c);
    return size[c*CW +: CW];
  endfunction

  function automatic logic [DW-1:0] pd(input int c);
    return pop_data[c*DW +: DW];
  endfunction

  task automatic push(input int c, input logic [DW-1:0] d);
    push_flag[c] = 1'b1;
    push_data[c*DW +: DW] = d;
  endtask

  // Advance one edge, sample point is 1 time unit later; requests are one-shot.
  task automatic tick();
    @(posedge clk);
    #1;
    push_flag = '0;
    pop_flag  = '0;
    err_clr   = '0;
    p5_push   = '0;
    p5_pop    = '0;
    p5_clr    = '0;
  endtask

  initial begin
    int occ;
    int wr;
    int rd;
    int k;

    // ---- reset state, sampled before any clock edge ----
    #3;
    check("rst_size",  size, '0);
    check("rst_empty", empty, 4'hF);
    check("rst_ae",    almost_empty, 4'hF);
    check("rst_full",  full, '0);
    check("rst_af",    almost_full, '0);
    check("rst_pdata", pop_data, '0);
    check("rst_err",   {overflow, underflow}, '0);
    check("rst_peak",  peak, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // ---- asynchronous reset mid-stream, ch0 holding 5 entries ----
    for (int i = 0; i < 5; i++) begin
      push(0, 32'h5000_0000 + i);
      tick();
    end
    check("ch0_fill5", sz(0), 5);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_size",  sz(0), 0);
    check("async_rst_empty", empty[0], 1'b1);
    check("async_rst_pdata", pd(0), '0);
    #1 reset_n = 1'b1;
    tick();
    check("post_rst_size", size, '0);

    // ---- ch1: fill to full, overflow, drain in order ----
    for (int i = 0; i < 8; i++) begin
      push(1, 32'hA000_0000 + i);
      tick();
      if (i == 4) check("ch1_af_at5", almost_full[1], 1'b0);
      if (i == 5) check("ch1_af_at6", almost_full[1], 1'b1);
    end
    check("ch1_full",  full[1], 1'b1);
    check("ch1_size8", sz(1), 8);
    push(1, 32'hA000_0008);
    tick();
    check("ch1_ovf",       overflow[1], 1'b1);
    check("ch1_size_ovf",  sz(1), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ch1_pop%0d", i), pd(1), 32'hA000_0000 + i);
      pop_flag[1] = 1'b1;
      tick();
    end
    check("ch1_empty",   empty[1], 1'b1);
    check("ch1_ae",      almost_empty[1], 1'b1);
    check("others_idle", {sz(0), sz(2), sz(3)}, '0);
    check("ovf_only_ch1", overflow, 4'b0010);
    err_clr[1] = 1'b1;
    tick();
    check("ch1_ovf_clr", overflow, '0);

    // ---- ch2: push+pop while full ----
    for (int i = 0; i < 8; i++) begin
      push(2, 32'hB000_0000 + i);
      tick();
    end
    check("ch2_head_b0", pd(2), 32'hB000_0000);
    push(2, 32'hB000_0008);
    pop_flag[2] = 1'b1;
    tick();
    check("ch2_size_keep", sz(2), 8);
    check("ch2_no_ovf",    overflow[2], 1'b0);
    check("ch2_still_full", full[2], 1'b1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("ch2_pop%0d", i), pd(2), 32'hB000_0000 + i);
      pop_flag[2] = 1'b1;
      tick();
    end
    check("ch2_empty", empty[2], 1'b1);

    // ---- ch3: push+pop on empty, err_clr behaviour ----
    push(3, 32'hC000_0000);
    pop_flag[3] = 1'b1;
    tick();
    check("ch3_size1", sz(3), 1);
    check("ch3_unf",   underflow[3], 1'b1);
    check("ch3_pdata", pd(3), 32'hC000_0000);
    err_clr[3] = 1'b1;
    tick();
    check("ch3_unf_clr", underflow[3], 1'b0);
    pop_flag[3] = 1'b1;
    tick();
    check("ch3_empty",      empty[3], 1'b1);
    check("ch3_unf_noerr",  underflow[3], 1'b0);
    err_clr[3]  = 1'b1;
    pop_flag[3] = 1'b1;
    tick();
    check("ch3_unf_setwins", underflow[3], 1'b1);
    check("unf_only_ch3",    underflow, 4'b1000);
    err_clr[3] = 1'b1;
    tick();

    // ---- ch0: fill to 7, drain to 2, then peak checks ----
    for (int i = 0; i < 7; i++) begin
      push(0, 32'h7000_0000 + i);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      pop_flag[0] = 1'b1;
      tick();
    end
    check("ch0_size2", sz(0), 2);
    check("ch0_head",  pd(0), 32'h7000_0005);
`ifdef QUEUE_MC_PEAK_EN
    check("ch0_peak7", peak[CW-1:0], 7);
    err_clr[0] = 1'b1;
    tick();
    check("ch0_peak_reload", peak[CW-1:0], 2);
`else
    check("peak_tied0", peak, '0);
    err_clr[0] = 1'b1;
    tick();
    check("peak_tied0_clr", peak, '0);
`endif

    // ---- DEPTH=5 instance: wrap with occupancy kept in 3..5 ----
    occ = 0;
    wr  = 0;
    rd  = 0;
    for (int i = 0; i < 3; i++) begin
      p5_push[0] = 1'b1;
      p5_pdata[DW-1:0] = 32'hD000_0000 + wr;
      wr++;
      occ++;
      tick();
    end
    for (int s = 0; s < 12; s++) begin
      k = pat[s % 6];
      if ((k & 1) != 0) begin
        p5_push[0] = 1'b1;
        p5_pdata[DW-1:0] = 32'hD000_0000 + wr;
        wr++;
        occ++;
      end
      if ((k & 2) != 0) begin
        check($sformatf("d5_pop_r%0d", rd), d5_data[DW-1:0], 32'hD000_0000 + rd);
        p5_pop[0] = 1'b1;
        rd++;
        occ--;
      end
      tick();
      check($sformatf("d5_size_s%0d", s), d5_size[CW5-1:0], occ);
      check($sformatf("d5_full_s%0d", s), d5_full[0], (occ == 5));
    end
    while (rd < wr) begin
      check($sformatf("d5_drain_r%0d", rd), d5_data[DW-1:0], 32'hD000_0000 + rd);
      p5_pop[0] = 1'b1;
      rd++;
      tick();
    end
    check("d5_empty",    d5_empty, 2'b11);
    check("d5_no_err",   {d5_ovf, d5_unf}, '0);
    check("d5_ch1_idle", d5_size[2*CW5-1:CW5], 0);
    check("main_ch1_idle_end", sz(1), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/queue_mc.md
Name: queue_mc

Overview:
- Multi-channel successor to the single-channel queue: NUM_CH independent FIFOs sharing one clock and reset.
- Each channel is first-word-fall-through, with per-channel occupancy, almost-full/almost-empty watermarks and sticky overflow/underflow flags.
- Push while full succeeds when a pop occurs in the same cycle.
- Sits between the packet ingress stage and the per-channel consumers.

Parameters:
- DATA_SIZE, 32, data word width in bits.
- DEPTH, 8, entries per channel; any value ≥2, not restricted to a power of two.
- NUM_CH, 4, number of independent channels.
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL.
- PTR_W, $clog2(DEPTH), pointer width (derived).
- CNT_W, $clog2(DEPTH+1), count width (derived; holds 0..DEPTH).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- push_flag  in  NUM_CH  per-channel push request.
- push_data  in  NUM_CH*DATA_SIZE  channel c occupies bits [c*DATA_SIZE +: DATA_SIZE].
- pop_flag  in  NUM_CH  per-channel pop request.
- pop_data  out  NUM_CH*DATA_SIZE  head entry per channel, same packing as push_data.
- err_clr  in  NUM_CH  clears that channel's sticky error flags (and peak, see Optional Feature).
- full  out  NUM_CH  count == DEPTH.
- empty  out  NUM_CH  count == 0.
- almost_full  out  NUM_CH  count ≥ AF_LEVEL.
- almost_empty  out  NUM_CH  count ≤ AE_LEVEL.
- size  out  NUM_CH*CNT_W  per-channel occupancy.
- overflow  out  NUM_CH  sticky: a push was dropped.
- underflow  out  NUM_CH  sticky: a pop was dropped.
- peak  out  NUM_CH*CNT_W  per-channel high-water mark (Optional Feature).

Behaviour:
- Reset (reset_n low, asynchronous): all head/tail pointers, counts, overflow, underflow and peak cleared. Outputs: empty=all 1s, full=0, almost_full=0 (AF_LEVEL ≥1), almost_empty=all 1s, size=0, pop_data=0. Memory is not reset.
- Reset asserted mid-operation discards all contents; no partial update is allowed on the reset edge.
- Channels are fully independent; no cross-channel interaction.
- Per channel, per clock edge, with count n:
  - push only, n<DEPTH: write at head, head++, n+1.
  - push only, n==DEPTH: data dropped, overflow<=1, no state change.
  - pop only, n>0: tail++, n-1.
  - pop only, n==0: underflow<=1, no state change.
  - push+pop, 0<n≤DEPTH: write at head, head++, tail++, n unchanged. This holds when full; the pop frees the slot.
  - push+pop, n==0: push accepted (n becomes 1), pop dropped, underflow<=1.
- Pointer wrap: the pointer equal to DEPTH-1 advances to 0. Supports non-power-of-two DEPTH.
- pop_data is combinational from memory[tail]: a pushed word is visible the cycle after the push edge (1-cycle latency), and the next word is visible immediately after the pop edge. pop_data is forced to 0 while empty.
- Flags full, empty, almost_full, almost_empty and size are combinational from the count register.
- overflow/underflow stay set until err_clr. If err_clr and a new error occur in the same cycle, the set wins.
- Elaboration check: AE_LEVEL < AF_LEVEL ≤ DEPTH; fatal error otherwise.

Optional Feature:
- Macro QUEUE_MC_PEAK_EN.
- Defined: peak[c] records the maximum count seen by channel c, updated on the same edge as the count. err_clr[c] reloads peak with the current post-edge count.
- Undefined: no peak registers; the peak port is present and tied to 0, so the interface is unchanged.

Decomposition:
- Package queue_mc_pkg holds:
  - function cnt_width(depth), returning $clog2(depth+1);
  - typedef ch_status_t as a packed struct of full, empty, almost_full, almost_empty, overflow, underflow.
- Sub-module queue_mc_ch: one channel (memory, pointers, count, sticky flags, optional peak).
- queue_mc instantiates NUM_CH copies of queue_mc_ch via generate and only packs/unpacks the buses.

Test Plan:
- Reset → size=0, empty=4'hF, almost_empty=4'hF, full=0, pop_data=0. Repeat with reset_n pulsed low mid-stream on ch0 holding 5 entries → ch0 size=0 immediately, before the next clk edge.
- Ch1 push 8 words A0..A7 → full[1]=1 and almost_full[1] from the 6th push. Then a 9th push → overflow[1]=1, size stays 8. Pop 8 → data A0..A7 in order, empty[1]=1.
- Ch2 full (8 entries) + simultaneous push B8 and pop → B0 popped, size stays 8, overflow[2]=0. After 8 further pops, last word = B8.
- Ch3 empty + simultaneous push C0 and pop → size=1, underflow[3]=1, pop_data=C0. err_clr[3] alone → underflow clears. err_clr with a simultaneous underflow → stays 1.
- DEPTH=5 build: 12 push/pop pairs interleaved around 3–5 occupancy → pointers wrap correctly, FIFO order preserved, no spurious flags. Other channels are unaffected throughout.
- QUEUE_MC_PEAK_EN: ch0 fill to 7, drain to 2 → peak=7. err_clr → peak=2. Build without the macro → peak=0 always.
